// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    // Fetch FSM encoding: FETCH=0, HOLD=1, DISCARD=2.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } if_state_e;

    // Bubble presented to IfStageReg when nothing valid is fetched.
    localparam logic [31:0] IF_NOP = 32'h0;

    // Default byte increment between sequential fetches.
    localparam int IF_PC_STEP_DEF = 4;

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: synchronous reset, branch load, sequential
// increment, otherwise hold. Load has priority over increment.
module if_pc_reg
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = IF_PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_seq
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Sequential successor wraps silently modulo 2^ADDR_W.
    assign pc_seq = pc_q + ADDR_W'(PC_STEP);
    assign pc     = pc_q;

    // Next PC: branch load beats increment beats hold.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_seq;
        end
    end

    // PC state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage front end: owns the PC, issues instruction-memory requests over
// a req/ack handshake and presents fetched words to IfStageReg.
// Optional feature macro: IF_PERF_CNT_EN adds perf_fetched / perf_wait.
module if_fetch_unit
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = IF_PC_STEP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              fetch_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic [31:0]       instruction_out,
    output logic              mem_wait
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_wait
`endif
);

    if_state_e         state_d, state_q;
    logic [ADDR_W-1:0] req_addr_d, req_addr_q;
    logic [31:0]       buf_d, buf_q;
    logic              pc_load;
    logic              pc_inc;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_seq;

    if_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .load      (pc_load),
        .load_addr (branch_addr),
        .inc       (pc_inc),
        .pc        (pc),
        .pc_seq    (pc_seq)
    );

    // Next-state, PC control and presented outputs for the fetch FSM.
    // In DISCARD the old request must complete before the redirected one
    // can go out, so req_addr only catches up with pc on that ack.
    always_comb begin
        state_d         = state_q;
        req_addr_d      = req_addr_q;
        buf_d           = buf_q;
        pc_load         = 1'b0;
        pc_inc          = 1'b0;
        imem_req        = 1'b1;
        fetch_valid     = 1'b0;
        instruction_out = IF_NOP;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    if (branch_taken) begin
                        pc_load    = 1'b1;
                        req_addr_d = branch_addr;
                    end else begin
                        fetch_valid     = 1'b1;
                        instruction_out = imem_rdata;
                        if (freeze) begin
                            buf_d   = imem_rdata;
                            state_d = ST_HOLD;
                        end else begin
                            pc_inc     = 1'b1;
                            req_addr_d = pc_seq;
                        end
                    end
                end else if (branch_taken) begin
                    pc_load = 1'b1;
                    state_d = ST_DISCARD;
                end
            end
            ST_HOLD: begin
                imem_req        = 1'b0;
                fetch_valid     = 1'b1;
                instruction_out = buf_q;
                if (branch_taken) begin
                    pc_load    = 1'b1;
                    req_addr_d = branch_addr;
                    state_d    = ST_FETCH;
                end else if (!freeze) begin
                    pc_inc     = 1'b1;
                    req_addr_d = pc_seq;
                    state_d    = ST_FETCH;
                end
            end
            ST_DISCARD: begin
                if (branch_taken) begin
                    pc_load = 1'b1;
                end
                if (imem_ack) begin
                    req_addr_d = branch_taken ? branch_addr : pc;
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    assign imem_addr = req_addr_q;
    assign mem_wait  = imem_req & ~imem_ack;
    assign pc_out    = fetch_valid ? pc_seq : '0;

    // FSM state, outstanding request address and freeze buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            req_addr_q <= RESET_PC;
            buf_q      <= IF_NOP;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_d, perf_fetched_q;
    logic [31:0] perf_wait_d, perf_wait_q;

    // Counters advance on consumed fetches and on memory wait cycles.
    always_comb begin
        perf_fetched_d = perf_fetched_q + 32'(fetch_valid & ~freeze);
        perf_wait_d    = perf_wait_q + 32'(mem_wait);
    end

    // Performance counter registers; wrap at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_wait_q    <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_wait_q    <= perf_wait_d;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_wait    = perf_wait_q;
`endif

`ifndef SYNTHESIS
    // An ack with no request outstanding is ignored by the FSM; flag it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_ack && !imem_req))
                else $error("imem_ack asserted while imem_req is low");
        end
    end
`endif

endmodule
